// File: rtl/bram_rmw_pkg.sv
// Shared types, default widths and the bit-mask merge helper
// used by the BRAM write-mask front end.
package bram_rmw_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  // Bits set in mask take the new value; the rest keep the old word.
  function automatic logic [DATA_W_DEF-1:0] wem_merge(
    input logic [DATA_W_DEF-1:0] old_v,
    input logic [DATA_W_DEF-1:0] new_v,
    input logic [DATA_W_DEF-1:0] mask
  );
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/bram_wem_rmw.sv
// Turns a bit-masked valid/ready request stream into whole-word BRAM port
// signals, using a two-cycle read-modify-write for partial writes.
module bram_wem_rmw
  import bram_rmw_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_A,
  input  logic [DATA_W-1:0] REQ_D,
  input  logic [DATA_W-1:0] REQ_WEM,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_Q,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              WE,
  output logic              CE,
  input  logic [DATA_W-1:0] Q
);

  state_e              state_q;
  logic                rsp_pend_q;
  logic [ADDR_W-1:0]   hold_a_q;
  logic [DATA_W-1:0]   hold_d_q;
  logic [DATA_W-1:0]   hold_m_q;

  logic accept;
  logic is_read;
  logic is_full;
  logic is_null;
  logic is_part;

  assign REQ_READY = !RST && (state_q == ST_IDLE);
  assign accept    = REQ_VALID && REQ_READY;

  assign is_read = !REQ_WE;
  assign is_full = REQ_WE && (&REQ_WEM);
  assign is_null = REQ_WE && !(|REQ_WEM);
  assign is_part = REQ_WE && !is_full && !is_null;

  assign RSP_VALID = rsp_pend_q;
  assign RSP_Q     = Q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rsp_pend_q <= 1'b0;
      hold_a_q   <= '0;
      hold_d_q   <= '0;
      hold_m_q   <= '0;
    end else begin
      rsp_pend_q <= accept && is_read;
      case (state_q)
        ST_IDLE: begin
          if (accept && is_part) begin
            state_q  <= ST_MERGE;
            hold_a_q <= REQ_A;
            hold_d_q <= REQ_D;
            hold_m_q <= REQ_WEM;
          end
        end
        ST_MERGE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // BRAM port is driven straight from request/state; reset forces it quiet,
  // which also drops a write still waiting in MERGE.
  always_comb begin
    A  = REQ_A;
    D  = REQ_D;
    CE = 1'b0;
    WE = 1'b0;
    if (!RST) begin
      if (state_q == ST_MERGE) begin
        A  = hold_a_q;
        D  = wem_merge(Q, hold_d_q, hold_m_q);
        CE = 1'b1;
        WE = 1'b1;
      end else if (accept && !is_null) begin
        CE = 1'b1;
        WE = is_full;
      end
    end
  end

endmodule

// File: tb/tb_bram_wem_rmw.sv
// Directed bench for bram_wem_rmw with a behavioural BRAM and a
// transaction-level reference model checked every cycle.
module tb_bram_wem_rmw;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [9:0]  REQ_A;
  logic [15:0] REQ_D;
  logic [15:0] REQ_WEM;
  logic        RSP_VALID;
  logic [15:0] RSP_Q;
  logic [9:0]  A;
  logic [15:0] D;
  logic        WE;
  logic        CE;
  logic [15:0] Q;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  bram_wem_rmw dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_A(REQ_A), .REQ_D(REQ_D), .REQ_WEM(REQ_WEM),
    .RSP_VALID(RSP_VALID), .RSP_Q(RSP_Q),
    .A(A), .D(D), .WE(WE), .CE(CE), .Q(Q)
  );

  // BRAM primitive: synchronous, whole-word write, Q holds on writes.
  logic [15:0] bram [1024];
  logic [15:0] bram_q;
  assign Q = bram_q;

  always @(posedge CLK) begin
    if (CE) begin
      if (WE) bram[A] <= D;
      else    bram_q  <= bram[A];
    end
  end

  // Reference model at the transaction level.
  logic [15:0] m_mem [1024];
  bit          m_busy = 1'b0;
  logic [9:0]  m_ha;
  logic [15:0] m_hv;
  bit          exp_v = 1'b0;
  logic [15:0] exp_q;
  bit          chk_en = 1'b0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bram[i]  = 16'h0;
      m_mem[i] = 16'h0;
    end
    bram_q = 16'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    chk_en = 1'b1;
    exp_v  = 1'b0;
    if (RST) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_mem[m_ha] = m_hv;
      m_busy      = 1'b0;
    end else if (REQ_VALID) begin
      if (!REQ_WE) begin
        exp_v = 1'b1;
        exp_q = m_mem[REQ_A];
      end else if (REQ_WEM == 16'hFFFF) begin
        m_mem[REQ_A] = REQ_D;
      end else if (REQ_WEM != 16'h0000) begin
        m_busy = 1'b1;
        m_ha   = REQ_A;
        m_hv   = (m_mem[REQ_A] & ~REQ_WEM) | (REQ_D & REQ_WEM);
      end
    end
  end

  logic ready_e, ce_e, we_e;

  always @(negedge CLK) begin
    if (chk_en) begin
      ready_e = !RST && !m_busy;
      ce_e = !RST && (m_busy || (REQ_VALID && !(REQ_WE && REQ_WEM == 16'h0)));
      we_e = !RST && (m_busy || (REQ_VALID && REQ_WE && REQ_WEM == 16'hFFFF));
      chk("req_ready", REQ_READY, ready_e);
      chk("ce", CE, ce_e);
      chk("we", WE, we_e);
      chk("rsp_valid", RSP_VALID, exp_v);
      if (exp_v) chk("rsp_q", RSP_Q, exp_q);
      if (!RST && m_busy) begin
        chk("merge_a", A, m_ha);
        chk("merge_d", D, m_hv);
      end else if (we_e) begin
        chk("wr_a", A, REQ_A);
        chk("wr_d", D, REQ_D);
      end
    end
  end

  task automatic idle();
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [9:0] a, input logic [15:0] d,
                       input logic [15:0] wem, output int waits);
    logic acc;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_A     = a;
    REQ_D     = d;
    REQ_WEM   = wem;
    waits     = 0;
    acc       = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge CLK);
      acc = REQ_READY;
      @(posedge CLK);
      #1;
      if (!acc) waits++;
    end
    if (!acc) chk("issue_accept", acc, 1);
  endtask

  task automatic read_chk(input string name, input logic [9:0] a, input logic [15:0] exp);
    int w;
    issue(1'b0, a, 16'h0, 16'h0, w);
    idle();
    @(negedge CLK);
    chk({name, "_valid"}, RSP_VALID, 1);
    chk(name, RSP_Q, exp);
    @(posedge CLK);
    #1;
  endtask

  logic [9:0]  v_a   [4] = '{10'h010, 10'h011, 10'h012, 10'h010};
  logic [15:0] v_d   [4] = '{16'hAAAA, 16'h5555, 16'hF00F, 16'h0FF0};
  logic [15:0] v_wem [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00F0};

  initial begin
    int w;
    RST       = 1'b1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_A     = 10'h001;
    REQ_D     = 16'hFFFF;
    REQ_WEM   = 16'hFFFF;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_ce", CE, 0);
      chk("rst_we", WE, 0);
      chk("rst_ready", REQ_READY, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle();
    @(negedge CLK);
    chk("ready_after_rst", REQ_READY, 1);
    @(posedge CLK);
    #1;

    issue(1'b1, 10'h3FF, 16'hBEEF, 16'hFFFF, w);
    read_chk("rd_3ff", 10'h3FF, 16'hBEEF);

    issue(1'b1, 10'd5, 16'h1234, 16'hFFFF, w);
    issue(1'b1, 10'd5, 16'hABCD, 16'h00FF, w);
    idle();
    @(negedge CLK);
    chk("merge_ready_low", REQ_READY, 0);
    chk("merge_we", WE, 1);
    chk("merge_d_lit", D, 16'h12CD);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("ready_back", REQ_READY, 1);
    @(posedge CLK);
    #1;
    read_chk("rd_5_partial", 10'd5, 16'h12CD);

    issue(1'b1, 10'd5, 16'h5A00, 16'hFF00, w);
    issue(1'b0, 10'd5, 16'h0000, 16'h0000, w);
    chk("b2b_read_wait", w, 1);
    idle();
    @(negedge CLK);
    chk("b2b_rsp_q", RSP_Q, 16'h5ACD);
    @(posedge CLK);
    #1;

    issue(1'b1, 10'd7, 16'h0F0F, 16'hFFFF, w);
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_A     = 10'd7;
    REQ_D     = 16'hFFFF;
    REQ_WEM   = 16'h0000;
    @(negedge CLK);
    chk("null_ce", CE, 0);
    chk("null_ready", REQ_READY, 1);
    @(posedge CLK);
    #1;
    read_chk("rd_7_null", 10'd7, 16'h0F0F);

    issue(1'b1, 10'd9, 16'h5555, 16'hFFFF, w);
    issue(1'b1, 10'd9, 16'hFFFF, 16'h0F0F, w);
    RST = 1'b1;
    idle();
    @(negedge CLK);
    chk("rst_merge_we", WE, 0);
    chk("rst_merge_ce", CE, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    read_chk("rd_9_dropped", 10'd9, 16'h5555);

    for (int i = 0; i < 4; i++) issue(1'b1, v_a[i], v_d[i], v_wem[i], w);
    issue(1'b0, 10'h010, 16'h0, 16'h0, w);
    issue(1'b0, 10'h011, 16'h0, 16'h0, w);
    issue(1'b0, 10'h012, 16'h0, 16'h0, w);
    issue(1'b0, 10'h3FF, 16'h0, 16'h0, w);
    idle();
    read_chk("rd_10_merged", 10'h010, 16'hAAFA);
    read_chk("rd_12", 10'h012, 16'hF00F);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
